// File: rtl/rr_shift_ctrl_if.sv
// Host command and operand-register control bundle for rr_shift_ctrl.
// The master side issues commands; the slave side (the sequencer) drives register controls.
interface rr_shift_ctrl_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 9
);
  logic             init;
  logic             ld_start;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_data;
  logic             ld_ready;
  logic             shr_req;
  logic [CNT_W-1:0] shr_cnt;
  logic             shr_fill;
  logic             busy;
  logic             done;
  logic             reg_we;
  logic             reg_sel_rs;
  logic             reg_set;
  logic [WIDTH-1:0] reg_regin;
  logic             reg_bit256;

  modport master (
    output init, ld_start, ld_valid, ld_data, shr_req, shr_cnt, shr_fill,
    input  ld_ready, busy, done, reg_we, reg_sel_rs, reg_set, reg_regin, reg_bit256
  );

  modport slave (
    input  init, ld_start, ld_valid, ld_data, shr_req, shr_cnt, shr_fill,
    output ld_ready, busy, done, reg_we, reg_sel_rs, reg_set, reg_regin, reg_bit256
  );
endinterface

// File: rtl/rr_shift_ctrl.sv
// Sequencer for the 256-bit right-shift operand register: turns init/load/shift commands
// into per-cycle register controls, with busy and a one-cycle done pulse per command.
module rr_shift_ctrl #(
  parameter int unsigned WORDS = 16,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 9
) (
  input logic            clk,
  input logic            rst_n,
  rr_shift_ctrl_if.slave bus
);

  localparam int unsigned WCNT_W = $clog2(WORDS);
  localparam logic [WCNT_W-1:0] LastWord = WCNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  MaxCnt   = CNT_W'(WORDS * WIDTH);

  typedef enum logic [2:0] {StIdle, StInit, StLoad, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;

  logic busy_q, done_q, set_q, shift_q, load_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      StIdle: begin
        // Fixed priority; losing requests in the same cycle are dropped.
        if (bus.init) begin
          state_d = StInit;
        end else if (bus.ld_start) begin
          state_d = StLoad;
          wcnt_d  = '0;
        end else if (bus.shr_req) begin
          if (bus.shr_cnt == '0) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
            scnt_d  = (bus.shr_cnt > MaxCnt) ? MaxCnt : bus.shr_cnt;
          end
        end
      end
      StInit: state_d = StDone;
      StLoad: begin
        if (bus.ld_valid) begin
          if (wcnt_q == LastWord) begin
            state_d = StDone;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      StShift: begin
        scnt_d = scnt_q - CNT_W'(1);
        if (scnt_q == CNT_W'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded controls are registered from the next state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      set_q   <= 1'b0;
      shift_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      set_q   <= (state_d == StInit);
      shift_q <= (state_d == StShift);
      load_q  <= (state_d == StLoad);
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ld_ready   = load_q;
  assign bus.reg_set    = set_q;
  assign bus.reg_sel_rs = shift_q;
  assign bus.reg_we     = set_q | shift_q | (load_q & bus.ld_valid);
  assign bus.reg_bit256 = shift_q & bus.shr_fill;
  // Gated so every output reads zero while idle or in reset.
  assign bus.reg_regin  = load_q ? bus.ld_data : {WIDTH{1'b0}};

endmodule

// File: tb/tb_rr_shift_ctrl.sv
// Self-checking bench for rr_shift_ctrl: models the 256-bit operand register from the
// control outputs and compares it with the arithmetic result of each command.
module tb_rr_shift_ctrl;
  localparam int unsigned WORDS = 16;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 9;
  localparam int unsigned NBITS = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rr_shift_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  rr_shift_ctrl #(.WORDS(WORDS), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Operand register driven only by the DUT's controls, plus event counters.
  logic [NBITS-1:0] opreg;
  int unsigned we_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned set_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.reg_we) we_cnt <= we_cnt + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.reg_set) set_cnt <= set_cnt + 1;
      if (bus.reg_we) begin
        if (bus.reg_set) opreg <= NBITS'(1);
        else if (bus.reg_sel_rs) opreg <= {bus.reg_bit256, opreg[NBITS-1:1]};
        else opreg <= {bus.reg_regin, opreg[NBITS-1:WIDTH]};
      end
    end
  end

  logic [NBITS-1:0] exp_reg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      sample();
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pulse_shift(input int unsigned cnt, input logic fill);
    bus.shr_req  = 1'b1;
    bus.shr_cnt  = CNT_W'(cnt);
    bus.shr_fill = fill;
    tick();
    bus.shr_req = 1'b0;
  endtask

  task automatic run_init(input logic also_ld, input logic also_shr);
    int lat;
    int unsigned we0, set0;
    we0  = we_cnt;
    set0 = set_cnt;
    tick();
    bus.init     = 1'b1;
    bus.ld_start = also_ld;
    bus.shr_req  = also_shr;
    bus.shr_cnt  = CNT_W'(9);
    tick();
    bus.init     = 1'b0;
    bus.ld_start = 1'b0;
    bus.shr_req  = 1'b0;
    wait_done(10, lat);
    exp_reg = NBITS'(1);
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL init_latency: got %0d expected 2", lat);
    end
    n_tests++;
    if ((we_cnt - we0) !== 1 || (set_cnt - set0) !== 1) begin
      n_fail++;
      $display("FAIL init_pulse: we %0d set %0d expected 1 and 1", we_cnt - we0, set_cnt - set0);
    end
    n_tests++;
    if (opreg !== exp_reg) begin
      n_fail++;
      $display("FAIL init_value: got %h expected %h", opreg, exp_reg);
    end
  endtask

  task automatic run_load(input logic [WIDTH-1:0] words[WORDS], input logic gap,
                          input logic inject);
    int lat;
    int unsigned we0, i, c;
    we0 = we_cnt;
    tick();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    i = 0;
    c = 0;
    while (i < WORDS && c < 200) begin
      bus.ld_valid = !(gap && (c % 3 == 2));
      bus.ld_data  = words[i];
      if (inject) bus.shr_req = (c == 4);
      bus.shr_cnt = CNT_W'(5);
      sample();
      if (inject && c == 5) begin
        n_tests++;
        if (bus.busy !== 1'b1 || bus.ld_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL load_ignore_shr: busy %b ready %b expected 1 1", bus.busy, bus.ld_ready);
        end
      end
      if (bus.ld_valid && bus.ld_ready) i++;
      tick();
      c++;
    end
    bus.ld_valid = 1'b0;
    bus.shr_req  = 1'b0;
    wait_done(10, lat);
    exp_reg = '0;
    for (int k = 0; k < WORDS; k++) exp_reg |= NBITS'(words[k]) << (WIDTH * k);
    n_tests++;
    if (i !== WORDS) begin
      n_fail++;
      $display("FAIL load_handshakes: got %0d expected %0d", i, WORDS);
    end
    n_tests++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL load_latency: got %0d expected 1", lat);
    end
    n_tests++;
    if ((we_cnt - we0) !== WORDS) begin
      n_fail++;
      $display("FAIL load_we_count: got %0d expected %0d", we_cnt - we0, WORDS);
    end
    n_tests++;
    if (opreg !== exp_reg) begin
      n_fail++;
      $display("FAIL load_value: got %h expected %h", opreg, exp_reg);
    end
  endtask

  task automatic run_shift(input int unsigned cnt, input logic fill);
    int lat;
    int unsigned we0, n;
    logic [NBITS-1:0] ones;
    ones = '1;
    n    = (cnt > NBITS) ? NBITS : cnt;
    we0  = we_cnt;
    tick();
    pulse_shift(cnt, fill);
    wait_done(NBITS + 10, lat);
    exp_reg = (exp_reg >> n) | (fill ? ~(ones >> n) : '0);
    n_tests++;
    if (lat !== int'(n + 1)) begin
      n_fail++;
      $display("FAIL shift%0d_latency: got %0d expected %0d", cnt, lat, n + 1);
    end
    n_tests++;
    if ((we_cnt - we0) !== n) begin
      n_fail++;
      $display("FAIL shift%0d_we_count: got %0d expected %0d", cnt, we_cnt - we0, n);
    end
    n_tests++;
    if (opreg !== exp_reg) begin
      n_fail++;
      $display("FAIL shift%0d_value: got %h expected %h", cnt, opreg, exp_reg);
    end
  endtask

  task automatic test_reset();
    logic [22:0] ov;
    int unsigned d0;
    bus.ld_data  = 16'hA5A5;
    bus.shr_fill = 1'b1;
    #12;
    ov = {bus.busy, bus.done, bus.reg_we, bus.reg_sel_rs, bus.reg_set, bus.reg_bit256,
          bus.ld_ready, bus.reg_regin};
    n_tests++;
    if (ov !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", ov);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_init(1'b0, 1'b0);
    tick();
    pulse_shift(150, 1'b1);
    repeat (50) sample();
    d0 = done_cnt;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.reg_sel_rs !== 1'b1) begin
      n_fail++;
      $display("FAIL midshift_active: busy %b sel_rs %b expected 1 1", bus.busy, bus.reg_sel_rs);
    end
    rst_n = 1'b0;
    #1;
    ov = {bus.busy, bus.done, bus.reg_we, bus.reg_sel_rs, bus.reg_set, bus.reg_bit256,
          bus.ld_ready, bus.reg_regin};
    n_tests++;
    if (ov !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h expected 0", ov);
    end
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) sample();
    n_tests++;
    if (bus.busy !== 1'b0 || done_cnt !== d0) begin
      n_fail++;
      $display("FAIL reset_abort: busy %b done pulses %0d expected 0 0", bus.busy, done_cnt - d0);
    end
    run_init(1'b0, 1'b0);
  endtask

  task automatic test_init_load();
    logic [WIDTH-1:0] words[WORDS];
    run_init(1'b0, 1'b0);
    for (int k = 0; k < WORDS; k++) words[k] = WIDTH'(k);
    run_load(words, 1'b1, 1'b0);
  endtask

  task automatic test_shift_edges();
    run_shift(1, 1'b1);
    run_shift(0, 1'b0);
    run_shift(300, $urandom_range(0, 1) == 1);
  endtask

  task automatic test_full_shift();
    logic [WIDTH-1:0] words[WORDS];
    for (int k = 0; k < WORDS; k++) words[k] = '1;
    run_load(words, 1'b0, 1'b0);
    run_shift(256, 1'b0);
  endtask

  task automatic test_priority();
    logic [WIDTH-1:0] words[WORDS];
    int unsigned we0;
    run_init(1'b1, 1'b1);
    we0 = we_cnt;
    tick();
    sample();
    n_tests++;
    if (bus.busy !== 1'b0 || we_cnt !== we0) begin
      n_fail++;
      $display("FAIL priority_dropped: busy %b extra we %0d expected 0 0", bus.busy, we_cnt - we0);
    end
    for (int k = 0; k < WORDS; k++) words[k] = WIDTH'($urandom);
    run_load(words, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int lat;
    int unsigned we0;
    we0 = we_cnt;
    tick();
    pulse_shift(3, 1'b0);
    wait_done(20, lat);
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL b2b_first_latency: got %0d expected 4", lat);
    end
    bus.shr_req = 1'b1;
    bus.shr_cnt = CNT_W'(7);
    tick();
    bus.shr_cnt = CNT_W'(2);
    sample();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_cycle_ignored: busy %b expected 0", bus.busy);
    end
    tick();
    bus.shr_req = 1'b0;
    wait_done(20, lat);
    exp_reg = exp_reg >> 5;
    n_tests++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d expected 3", lat);
    end
    n_tests++;
    if ((we_cnt - we0) !== 5) begin
      n_fail++;
      $display("FAIL b2b_we_count: got %0d expected 5", we_cnt - we0);
    end
    n_tests++;
    if (opreg !== exp_reg) begin
      n_fail++;
      $display("FAIL b2b_value: got %h expected %h", opreg, exp_reg);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] words[WORDS];
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < WORDS; k++) words[k] = WIDTH'($urandom);
      run_load(words, $urandom_range(0, 1) == 1, 1'b0);
      run_shift($urandom_range(0, 300), $urandom_range(0, 1) == 1);
      run_shift($urandom_range(0, 40), $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    bus.init     = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.shr_req  = 1'b0;
    bus.shr_cnt  = '0;
    bus.shr_fill = 1'b0;
    exp_reg      = '0;
    test_reset();
    test_init_load();
    test_shift_edges();
    test_full_shift();
    test_priority();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
